// File: rtl/window5x5_ctrl_if.sv
// Pixel-stream and window-status bundle between a raster pixel source and window5x5_ctrl.
// Handshake: a pixel moves on every rising edge where in_valid and in_ready are both high; the source holds in_pixel/in_sof stable until then.
interface window5x5_ctrl_if #(
    parameter int XW = 12,
    parameter int YW = 11
);
    logic          in_valid;
    logic [7:0]    in_pixel;
    logic          in_sof;
    logic          in_ready;
    logic          shift_en;
    logic [7:0]    out_pixel;
    logic          win_valid;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          frame_done;
    logic          err_sof;

    modport master (
        output in_valid, in_pixel, in_sof,
        input  in_ready, shift_en, out_pixel, win_valid, win_x, win_y, frame_done, err_sof
    );

    modport slave (
        input  in_valid, in_pixel, in_sof,
        output in_ready, shift_en, out_pixel, win_valid, win_x, win_y, frame_done, err_sof
    );
endinterface

// File: rtl/window5x5_ctrl.sv
// Sequencing controller for a 5x5 sliding window: frame lock, shift enable, position tracking, window qualification.
// Optional macro WIN_CTRL_SOF_RESYNC_EN: a mid-frame in_sof restarts the frame at (0,0) instead of being counted as data.
module window5x5_ctrl #(
    parameter int W  = 3124,
    parameter int H  = 2048,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H)
) (
    input  logic       clk,
    input  logic       rst,
    window5x5_ctrl_if.slave bus,
    output logic [1:0] o_dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [XW-1:0] COL_LAST  = XW'(W - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(H - 1);
    localparam logic [YW-1:0] FILL_LAST = YW'(3);
    localparam logic [XW-1:0] X_MIN     = XW'(4);
    localparam logic [YW-1:0] Y_MIN     = YW'(4);

    state_t        r_state, w_state_nxt;
    logic [XW-1:0] r_col, w_col_nxt;
    logic [YW-1:0] r_row, w_row_nxt;
    logic          r_win_valid, r_err_sof;
    logic [XW-1:0] r_win_x;
    logic [YW-1:0] r_win_y;
    logic          w_ready, w_acc, w_shift, w_sof_mid, w_restart;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;

    assign w_ready   = (r_state != DONE);
    assign w_acc     = bus.in_valid & w_ready;
    assign w_shift   = w_acc & ((r_state != IDLE) | bus.in_sof);
    assign w_sof_mid = w_acc & bus.in_sof & ((r_state == FILL) | (r_state == RUN));
`ifdef WIN_CTRL_SOF_RESYNC_EN
    assign w_restart = w_acc & bus.in_sof;
`else
    assign w_restart = w_acc & bus.in_sof & (r_state == IDLE);
`endif
    // Coordinates of the pixel being shifted this cycle; a (re)start pixel is always (0,0).
    assign w_x = w_restart ? '0 : r_col;
    assign w_y = w_restart ? '0 : r_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        case (r_state)
            DONE: w_state_nxt = IDLE;
            default: begin
                if (w_restart) begin
                    w_state_nxt = FILL;
                    w_col_nxt   = XW'(1);
                    w_row_nxt   = '0;
                end else if (w_shift) begin
                    if (r_col == COL_LAST) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + YW'(1);
                        if ((r_state == FILL) && (r_row == FILL_LAST)) begin
                            w_state_nxt = RUN;
                        end
                        if ((r_state == RUN) && (r_row == ROW_LAST)) begin
                            w_state_nxt = DONE;
                            w_row_nxt   = '0;
                        end
                    end else begin
                        w_col_nxt = r_col + XW'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        bus.in_ready   = w_ready;
        bus.shift_en   = w_shift;
        bus.out_pixel  = bus.in_pixel;
        bus.frame_done = (r_state == DONE);
        bus.win_valid  = r_win_valid;
        bus.win_x      = r_win_x;
        bus.win_y      = r_win_y;
        bus.err_sof    = r_err_sof;
        o_dbg_state    = r_state;
    end

    // Qualification is purely counter-based, so stale line-buffer data never yields a valid window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_x     <= '0;
            r_win_y     <= '0;
            r_err_sof   <= 1'b0;
        end else begin
            r_err_sof <= w_sof_mid;
            if (w_shift) begin
                r_win_valid <= (w_y >= Y_MIN) && (w_x >= X_MIN);
                r_win_x     <= w_x - XW'(2);
                r_win_y     <= w_y - YW'(2);
            end else begin
                r_win_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window5x5_ctrl.sv
// Directed bench for window5x5_ctrl at W=8, H=6; expectations follow WIN_CTRL_SOF_RESYNC_EN when defined.
module tb_window5x5_ctrl;
    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        logic valid;
        logic sof;
        logic exp_ready;
        logic exp_shift;
    } vec_t;

    typedef struct {
        int x;
        int y;
    } win_t;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    window5x5_ctrl_if #(.XW(3), .YW(3)) bus ();

    window5x5_ctrl #(.W(W), .H(H)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc, last_shift_cyc, n_shift, n_win, n_done, n_err, n_bubble, n_stall, first_win_shift;
    logic prev_shift;
    logic [15:0] exp_q[$];
    vec_t vecs[8];
    win_t win_tab[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        n_shift = 0; n_win = 0; n_done = 0; n_err = 0; n_bubble = 0; n_stall = 0;
        first_win_shift = -1;
        exp_q.delete();
    endtask

    task automatic push_windows();
        for (int i = 0; i < 8; i++) exp_q.push_back({8'(win_tab[i].x), 8'(win_tab[i].y)});
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic sof, input bit gap);
        logic ok;
        int guard;
        if (gap && ($urandom_range(0, 1) == 1)) idle(1);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = 8'($urandom_range(0, 255));
        guard = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 10);
        if (!ok) chk("accept_timeout", 32'(guard), 0);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int npix, input int sof2, input bit gap);
        for (int i = 0; i < npix; i++) send_pixel((i == 0) || (i == sof2), gap);
    endtask

    task automatic check_frame(input string tag, input int e_win, input int e_done, input int e_err,
                               input int e_first, input int e_shift);
        idle(4);
        chk({tag, "_n_win"}, 32'(n_win), 32'(e_win));
        chk({tag, "_exp_left"}, 32'(exp_q.size()), 0);
        chk({tag, "_n_done"}, 32'(n_done), 32'(e_done));
        chk({tag, "_n_bubble"}, 32'(n_bubble), 32'(e_done));
        chk({tag, "_n_err"}, 32'(n_err), 32'(e_err));
        chk({tag, "_first_win"}, 32'(first_win_shift), 32'(e_first));
        chk({tag, "_n_shift"}, 32'(n_shift), 32'(e_shift));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_shift_en"}, 32'(bus.shift_en), 0);
        chk({tag, "_win_valid"}, 32'(bus.win_valid), 0);
        chk({tag, "_win_x"}, 32'(bus.win_x), 0);
        chk({tag, "_win_y"}, 32'(bus.win_y), 0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
        chk({tag, "_err_sof"}, 32'(bus.err_sof), 0);
        chk({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    // Scoreboard: every window must follow a shift and match the next expected centre.
    always @(negedge clk) begin
        if (rst) begin
            prev_shift = 1'b0;
        end else begin
            logic [15:0] e;
            cyc++;
            if (bus.win_valid) begin
                chk("win_after_shift", 32'(prev_shift), 1);
                if (first_win_shift < 0) first_win_shift = n_shift;
                n_win++;
                if (exp_q.size() == 0) begin
                    chk("win_unexpected", 32'(bus.win_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("win_x", 32'(bus.win_x), 32'(e[15:8]));
                    chk("win_y", 32'(bus.win_y), 32'(e[7:0]));
                end
            end
            if (!bus.in_ready) begin
                n_bubble++;
                chk("bubble_is_done", 32'(bus.frame_done), 1);
            end
            if (bus.in_valid && !bus.in_ready) n_stall++;
            if (bus.frame_done) begin
                n_done++;
                chk("done_latency", 32'(cyc), 32'(last_shift_cyc + 1));
            end
            if (bus.err_sof) n_err++;
            if (bus.in_valid) chk("out_pixel", 32'(bus.out_pixel), 32'(bus.in_pixel));
            prev_shift = bus.shift_en;
            if (bus.shift_en) begin
                n_shift++;
                last_shift_cyc = cyc;
            end
        end
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0};
        win_tab[0] = '{2, 2}; win_tab[1] = '{3, 2}; win_tab[2] = '{4, 2}; win_tab[3] = '{5, 2};
        win_tab[4] = '{2, 3}; win_tab[5] = '{3, 3}; win_tab[6] = '{4, 3}; win_tab[7] = '{5, 3};

        cyc = 0; last_shift_cyc = -10; prev_shift = 1'b0;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_pixel = 8'h00;
        rst = 1'b0;
        clear_counts();
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle vectors: pixels without sof are consumed but never shifted.
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = vecs[i].valid;
            bus.in_sof   = vecs[i].sof;
            bus.in_pixel = 8'(i * 17);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_shift", i), 32'(bus.shift_en), 32'(vecs[i].exp_shift));
            chk($sformatf("vec%0d_win_valid", i), 32'(bus.win_valid), 0);
            chk($sformatf("vec%0d_state", i), 32'(dbg_state), 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;

        push_windows();
        send_frame(48, -1, 1'b0);
        check_frame("frame", 8, 1, 0, 37, 48);
        chk("frame_n_stall", 32'(n_stall), 0);

        clear_counts();
        push_windows();
        send_frame(48, -1, 1'b1);
        check_frame("gaps", 8, 1, 0, 37, 48);

        clear_counts();
        push_windows();
`ifdef WIN_CTRL_SOF_RESYNC_EN
        send_frame(68, 20, 1'b0);
        check_frame("midsof", 8, 1, 1, 57, 68);
`else
        send_frame(48, 20, 1'b0);
        check_frame("midsof", 8, 1, 1, 37, 48);
`endif

        clear_counts();
        send_frame(30, -1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
        clear_counts();
        push_windows();
        send_frame(48, -1, 1'b0);
        check_frame("after_rst", 8, 1, 0, 37, 48);

        clear_counts();
        push_windows();
        push_windows();
        send_frame(96, 48, 1'b0);
        check_frame("b2b", 16, 2, 0, 37, 96);
        chk("b2b_n_stall", 32'(n_stall), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/window5x5_ctrl.md
# window5x5_ctrl

Sequencing controller for the 5x5 sliding-window datapath (four line buffers of depth W plus a 5x5 register array). It accepts a raster pixel stream through a valid/ready handshake and locks onto frame start. It issues a shift enable to the clock-enabled window datapath for every accepted pixel, tracks column and row position, and flags when the 25 window registers hold a fully valid neighbourhood. It sits between the sensor/DMA pixel source and the 5x5 filter kernels and tells the kernels which window outputs to use.

## Interface
- W, default 3124: image width in pixels; equals the line-buffer depth of the window datapath.
- H, default 2048: image height in lines.
- XW, default $clog2(W): column counter and win_x width.
- YW, default $clog2(H): row counter and win_y width.

- clk  in  1  rising-edge clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source has a pixel.
- in_pixel  in  8  pixel data.
- in_sof  in  1  qualifies the current pixel as (0,0) of a frame; meaningful only with in_valid.
- in_ready  out  1  controller accepts a pixel this cycle.
- shift_en  out  1  window datapath clock enable; advances line buffers and window registers.
- out_pixel  out  8  pixel to the window datapath; equal to in_pixel (combinational).
- win_valid  out  1  window registers hold a complete 5x5 neighbourhood of the current frame.
- win_x  out  XW  column of the window centre (w12).
- win_y  out  YW  row of the window centre (w12).
- frame_done  out  1  one-cycle pulse after the last pixel (W-1,H-1) is accepted.
- err_sof  out  1  one-cycle pulse when in_sof arrives mid-frame.

## Operation
- Accept condition: acc = in_valid & in_ready.
- shift_en = acc & (state != IDLE | in_sof). In IDLE, pixels without in_sof are consumed and discarded; no shift occurs.
- State IDLE:
  - in_ready = 1.
  - acc & in_sof: pixel taken as (0,0); col <= 1; row <= 0; go to FILL.
- State FILL:
  - Covers rows 0..3. Each accept increments col.
  - At col = W-1, col wraps to 0 and row increments.
  - Leaving row 3 goes to RUN.
- State RUN:
  - Covers rows 4..H-1; same counting as FILL.
  - Accept of (W-1,H-1) goes to DONE.
- State DONE:
  - in_ready = 0 for exactly one cycle; frame_done = 1.
  - Next state IDLE.
- Window qualification (registered at the edge that shifts pixel (x,y)):
  - win_valid <= (y >= 4) & (x >= 4).
  - win_x <= x-2; win_y <= y-2.
  - Cycles without shift_en: win_valid <= 0; win_x/win_y hold.
- Stale line-buffer contents from the previous frame never produce win_valid, because qualification is counter-based.
- No horizontal wrap windows: x = 0..3 of every row give win_valid = 0 even though the registers contain the previous row's tail.
- Mid-frame in_sof in FILL/RUN:
  - Without the macro below: the pixel is treated as ordinary data, counting continues, and err_sof pulses.
  - With the macro: see Configuration.
- W < 5 or H < 5 is unsupported; the bench does not exercise it.

## Timing
- Reset values:
  - state = IDLE, col = 0, row = 0.
  - in_ready = 1, shift_en = 0 (combinational from in_valid).
  - win_valid = 0, win_x = 0, win_y = 0, frame_done = 0, err_sof = 0.
- Reset is asynchronous at any time, including mid-frame. The line-buffer contents are not cleared; the counters guarantee no false win_valid afterwards.
- in_ready, shift_en and out_pixel are combinational from state and inputs; zero latency.
- win_valid/win_x/win_y: one cycle after the accepting edge, aligned with the window register update.
- frame_done: asserted the cycle after the final accept (while in DONE).
- err_sof: asserted the cycle after the offending accept.
- Throughput: one pixel per cycle, except one bubble per frame (DONE).
- Back-pressure: none is generated beyond DONE; in_valid gaps stall everything, and counters hold.

## Configuration
- WIN_CTRL_SOF_RESYNC_EN:
  - Defined: a mid-frame in_sof is accepted as (0,0). col <= 1, row <= 0, state <= FILL, err_sof pulses, and win_valid is 0 until the new frame reaches (4,4).
  - Undefined: the mid-frame sof bit is ignored apart from the err_sof pulse.

## Test plan
- W=8, H=6, full frame of 48 pixels with in_valid constant: 8 win_valid pulses, the first with centre (2,2) and the last (5,3); frame_done one cycle after pixel 47; in_ready low exactly that cycle.
- 5 pixels without sof, then a frame: the 5 pixels produce no shift_en, and the counts match the first test.
- Random in_valid gaps (about 50%) over a frame: same win_x/win_y sequence as the first test; win_valid is never high without a preceding shift.
- in_sof at pixel 20: err_sof pulse. Without the macro, the frame ends at original pixel 47. With WIN_CTRL_SOF_RESYNC_EN, it restarts and the first window is (2,2) at 36 accepts after the resync.
- rst asserted at pixel 30, then a new frame: all outputs return to reset values immediately, and there is no win_valid before the new (4,4).
- Two back-to-back frames: exactly one bubble between them, and the second frame's windows are identical in position to the first.
